// File: rtl/game_pkg.sv
// Shared game phase codes and helpers, common to the flow controller and the display.
package game_pkg;

  localparam int STATE_W = 4;

  localparam logic [STATE_W-1:0] IDLE  = 4'd0;
  localparam logic [STATE_W-1:0] READY = 4'd1;
  localparam logic [STATE_W-1:0] PLAY  = 4'd2;
  localparam logic [STATE_W-1:0] POINT = 4'd3;
  localparam logic [STATE_W-1:0] WIN0  = 4'd4;
  localparam logic [STATE_W-1:0] WIN1  = 4'd5;
  localparam logic [STATE_W-1:0] DRAW  = 4'd6;

  // Two-digit BCD of a 0..99 value, {tens, ones}.
  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/sec_tick.sv
// One-second prescaler: counts 0..CLK_HZ-1, tick is high for the cycle at CLK_HZ-1.
// Synchronous clear restarts the second so a phase always lasts whole seconds.
module sec_tick #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/game_flow_ctrl.sv
// Two-player game sequencer: phase FSM, score registers and BCD round timer.
// All outputs are registered; inputs affect outputs one edge later.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int READY_SEC = 3,
  parameter int ROUND_SEC = 30,
  parameter int WIN_SCORE = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         p0_hit,
  input  logic         p1_hit,
  output logic [3:0]   state,
  output logic [3:0]   score0,
  output logic [3:0]   score1,
  output logic [3:0]   cnt0,
  output logic [3:0]   cnt1
);

  localparam logic [7:0] ROUND_BCD = to_bcd(ROUND_SEC);
  localparam logic [3:0] READY_V   = 4'(READY_SEC);
  localparam logic [3:0] WIN_V     = 4'(WIN_SCORE);

  logic [STATE_W-1:0] state_n;
  logic               tick;
  logic               clr;
  logic               hit0;
  logic               hit1;
  logic               expire;
  logic [3:0]         rnd1, rnd0, rdy;
  logic [3:0]         score0_n, score1_n, rnd1_n, rnd0_n, rdy_n, cnt1_n, cnt0_n;

  sec_tick #(.CLK_HZ(CLK_HZ)) u_sec_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  // Every phase change restarts the second.
  assign clr    = (state_n != state);
  assign hit0   = p0_hit & ~p1_hit;
  assign hit1   = p1_hit & ~p0_hit;
  assign expire = (rnd1 == 4'd0) && (rnd0 <= 4'd1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start) state_n = READY;
      READY: if (tick && rdy <= 4'd1) state_n = PLAY;
      PLAY: begin
        if (hit0 || hit1) begin
          state_n = POINT;
        end else if (tick && expire) begin
          if (score0 > score1)      state_n = WIN0;
          else if (score1 > score0) state_n = WIN1;
          else                      state_n = DRAW;
        end
      end
      POINT: begin
        if (tick) begin
          if (score0 == WIN_V)      state_n = WIN0;
          else if (score1 == WIN_V) state_n = WIN1;
          else                      state_n = READY;
        end
      end
      WIN0, WIN1, DRAW: if (start) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The round timer lives in rnd1:rnd0 and survives POINT/READY, so play resumes where it froze.
  always_comb begin
    score0_n = score0;
    score1_n = score1;
    rnd1_n   = rnd1;
    rnd0_n   = rnd0;
    rdy_n    = rdy;
    case (state)
      IDLE:  rdy_n = READY_V;
      READY: if (tick && rdy > 4'd1) rdy_n = rdy - 4'd1;
      PLAY: begin
        if (hit0) begin
          if (score0 < WIN_V) score0_n = score0 + 4'd1;
        end else if (hit1) begin
          if (score1 < WIN_V) score1_n = score1 + 4'd1;
        end else if (tick) begin
          if (expire) begin
            rnd1_n = 4'd0;
            rnd0_n = 4'd0;
          end else if (rnd0 == 4'd0) begin
            rnd0_n = 4'd9;
            rnd1_n = rnd1 - 4'd1;
          end else begin
            rnd0_n = rnd0 - 4'd1;
          end
        end
      end
      POINT: rdy_n = READY_V;
      WIN0, WIN1, DRAW: begin
        if (start) begin
          score0_n = 4'd0;
          score1_n = 4'd0;
          rnd1_n   = ROUND_BCD[7:4];
          rnd0_n   = ROUND_BCD[3:0];
        end
      end
      default: ;
    endcase
    if (state_n == READY) begin
      cnt1_n = 4'd0;
      cnt0_n = rdy_n;
    end else begin
      cnt1_n = rnd1_n;
      cnt0_n = rnd0_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      score0 <= 4'd0;
      score1 <= 4'd0;
      rnd1   <= ROUND_BCD[7:4];
      rnd0   <= ROUND_BCD[3:0];
      rdy    <= READY_V;
      cnt1   <= ROUND_BCD[7:4];
      cnt0   <= ROUND_BCD[3:0];
    end else begin
      score0 <= score0_n;
      score1 <= score1_n;
      rnd1   <= rnd1_n;
      rnd0   <= rnd0_n;
      rdy    <= rdy_n;
      cnt1   <= cnt1_n;
      cnt0   <= cnt0_n;
    end
  end

endmodule
